uart_ram_loader: RTL and testbench

- Sits between the UART byte receiver and the RAM second write port (wEn2/addr2/dataIn2).
- Packs incoming serial bytes little-endian into 32-bit words and writes each completed word to RAM at an auto-incrementing word address.
- The CPU sets the start address through the memory map (set_addr/start_addr).
- Discards stalled partial words after a timeout and flags the error.

---
 rtl/uart_ram_loader.sv | 101 ++++++++++
 tb/tb_uart_ram_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to RAM port 2
// at an auto-incrementing word address; stalled partial words time out.
module uart_ram_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  set_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  wrapped,
  output logic [CNT_WIDTH-1:0]  words_written
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        lane;
  logic [31:0]       asm_word;
  logic [IDLE_W-1:0] idle_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] k,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Stage 0: byte assembly, idle timeout and word hand-off into ram_data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane        <= 2'd0;
      asm_word    <= '0;
      idle_cnt    <= '0;
      ram_we      <= 1'b0;
      ram_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (set_addr) begin
        // A byte arriving with set_addr starts the new stream in lane 0
        lane        <= byte_valid ? 2'd1 : 2'd0;
        asm_word    <= byte_valid ? {24'd0, byte_data} : 32'd0;
        idle_cnt    <= '0;
        err_timeout <= 1'b0;
      end else if (byte_valid) begin
        idle_cnt <= '0;
        lane     <= lane + 2'd1;
        if (lane == 2'd3) begin
          ram_data <= insert_byte(asm_word, lane, byte_data);
          ram_we   <= 1'b1;
          asm_word <= '0;
        end else begin
          asm_word <= insert_byte(asm_word, lane, byte_data);
        end
      end else if (lane != 2'd0) begin
        if (idle_cnt == IDLE_LAST) begin
          lane        <= 2'd0;
          asm_word    <= '0;
          idle_cnt    <= '0;
          err_timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // Stage 1: address advance and bookkeeping after each write pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_addr      <= '0;
      words_written <= '0;
      wrapped       <= 1'b0;
    end else if (set_addr) begin
      ram_addr      <= start_addr;
      words_written <= '0;
      wrapped       <= 1'b0;
    end else if (ram_we) begin
      ram_addr      <= ram_addr + 1'b1;
      words_written <= sat_inc(words_written);
      if (&ram_addr) wrapped <= 1'b1;
    end
  end

  assign busy = (lane != 2'd0) || ram_we;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed and randomized bench for uart_ram_loader against a byte/word-level model.
module tb_uart_ram_loader;

  localparam int AW = 12;
  localparam int TO = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          set_addr;
  logic [AW-1:0] start_addr;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic          busy;
  logic          err_timeout;
  logic          wrapped;
  logic [CW-1:0] words_written;

  uart_ram_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .set_addr(set_addr), .start_addr(start_addr), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .err_timeout(err_timeout), .wrapped(wrapped),
    .words_written(words_written)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes collected so far, the next write address and flags
  int            nbuf;
  logic [31:0]   wbuf;
  int            acc;
  logic [AW-1:0] m_addr;
  int            m_cnt;
  logic          m_err;
  logic          m_wrap;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    nbuf = 0; wbuf = '0; acc = 0; m_addr = '0; m_cnt = 0; m_err = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wbuf = wbuf | (32'(b) << (8 * nbuf));
    nbuf++;
    acc = 0;
    if (nbuf == 4) begin
      exp_addr.push_back(m_addr);
      exp_data.push_back(wbuf);
      if (m_addr == {AW{1'b1}}) m_wrap = 1'b1;
      m_addr = m_addr + 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
      nbuf = 0;
      wbuf = '0;
    end
  endtask

  task automatic model_set(input logic [AW-1:0] a);
    m_addr = a; m_cnt = 0; m_err = 1'b0; m_wrap = 1'b0; nbuf = 0; wbuf = '0; acc = 0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    @(posedge clock); #1;
    byte_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
    if (nbuf > 0) begin
      acc += n;
      if (acc >= TO) begin
        nbuf = 0; wbuf = '0; acc = 0; m_err = 1'b1;
      end
    end
  endtask

  task automatic do_set(input logic [AW-1:0] a);
    set_addr = 1'b1; start_addr = a;
    @(posedge clock); #1;
    set_addr = 1'b0;
    model_set(a);
  endtask

  task automatic do_set_byte(input logic [AW-1:0] a, input logic [7:0] b);
    set_addr = 1'b1; start_addr = a; byte_valid = 1'b1; byte_data = b;
    @(posedge clock); #1;
    set_addr = 1'b0; byte_valid = 1'b0;
    model_set(a);
    model_byte(b);
  endtask

  task automatic settle_check(input string tag);
    idle(2);
    chk({tag, "_addr"}, 32'(ram_addr), 32'(m_addr));
    chk({tag, "_cnt"}, 32'(words_written), 32'(m_cnt));
    chk({tag, "_err"}, 32'(err_timeout), 32'(m_err));
    chk({tag, "_wrap"}, 32'(wrapped), 32'(m_wrap));
    chk({tag, "_busy"}, 32'(busy), 32'(nbuf != 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_data"}, ram_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
    chk({tag, "_wrap"}, 32'(wrapped), 32'd0);
    chk({tag, "_cnt"}, 32'(words_written), 32'd0);
  endtask

  // Write scoreboard: every ram_we pulse must match the next expected write
  always @(negedge clock) begin
    if (!reset && ram_we === 1'b1) begin
      checks++;
      assert (exp_addr.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_data);
      end
      if (exp_addr.size() > 0) begin
        chk("wr_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
        chk("wr_data", ram_data, exp_data.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1; byte_valid = 1'b0; byte_data = '0; set_addr = 1'b0; start_addr = '0;
    model_clear();
    #12;
    check_zero("reset");
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // 1: single word and exact write latency
    do_set(12'h010);
    send(8'h78); send(8'h56); send(8'h34);
    chk("t1_busy_partial", 32'(busy), 32'd1);
    send(8'h12);
    chk("t1_we", 32'(ram_we), 32'd1);
    chk("t1_addr", 32'(ram_addr), 32'h010);
    chk("t1_data", ram_data, 32'h12345678);
    @(posedge clock); #1;
    chk("t1_we_off", 32'(ram_we), 32'd0);
    chk("t1_addr_next", 32'(ram_addr), 32'h011);
    chk("t1_cnt", 32'(words_written), 32'd1);
    idle(1);

    // 2: back-to-back bytes, 5th lands in the ram_we cycle
    do_set(12'h010);
    for (int i = 0; i < 8; i++) send(8'($urandom));
    settle_check("t2");

    // 3: timeout discards a partial word, address unchanged
    send(8'hAA); send(8'hBB);
    idle(20);
    settle_check("t3");
    chk("t3_err_set", 32'(err_timeout), 32'd1);
    send_word($urandom);
    settle_check("t3b");

    // byte arriving on the expiry cycle wins
    do_set(12'h040);
    send(8'h01); send(8'h02); send(8'h03);
    idle(TO - 1);
    send(8'h04);
    settle_check("t3c");

    // 4: wrap from max address
    do_set(12'hFFF);
    send_word($urandom); send_word($urandom);
    settle_check("t4");
    chk("t4_wrapped", 32'(wrapped), 32'd1);
    do_set(12'h020);
    settle_check("t4_clear");

    // 5: set_addr in the ram_we cycle
    send_word(32'hCAFEF00D);
    do_set(12'h300);
    settle_check("t5");
    send_word(32'h0BADBEEF);
    settle_check("t5b");

    // set_addr together with a byte starts the new stream in lane 0
    send(8'h55); send(8'h66);
    do_set_byte(12'h080, 8'hD1);
    send(8'hD2); send(8'hD3); send(8'hD4);
    settle_check("t5c");

    // counter saturation
    do_set(12'h100);
    for (int i = 0; i < CNT_MAX + 2; i++) send_word($urandom);
    settle_check("sat");

    // randomized stream with occasional long gaps
    do_set(12'($urandom));
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end
    settle_check("rand");

    // 6: asynchronous reset mid-word
    do_set(12'h123);
    send_word($urandom);
    send(8'h11); send(8'h22); send(8'h33);
    #2 reset = 1'b1;
    #1;
    check_zero("t6");
    model_clear();
    #2 reset = 1'b0;
    @(posedge clock); #1;
    send_word($urandom);
    settle_check("t6b");

    chk("pending_writes", 32'(exp_addr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
